// File: rtl/seg_scan_3d.sv
// seg_scan_3d: time-multiplexed scanner for a three-digit common-anode 7-segment display.
//
// Latches the decoder's hundreds/tens/units patterns on load_i into a pending buffer and
// commits them to the display shadow only at a frame boundary. A commit is either from
// pending or from a load_i that lands on the boundary cycle. The block then scans units,
// tens and hundreds in turn, with a GUARD-cycle all-off gap at the start of each slot.
//
// Optional feature: define SEG_SCAN_BLANK_EN to blank leading zeros in the hundreds and
// tens digits. Units is never blanked.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   hun_i     hundreds segments {a..g}, active-low
//   ten_i     tens segments {a..g}, active-low
//   uni_i     units segments {a..g}, active-low
//   load_i    one-cycle strobe to capture hun_i/ten_i/uni_i
//   seg_o     shared segment bus {a..g}, active-low, registered
//   an_o      digit enables {hundreds,tens,units}, active-low, registered
//   commit_o  one-cycle pulse the cycle after a boundary that updated the shadow

module seg_scan_3d #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 16,
  parameter logic [6:0]  ZERO_PAT    = 7'b0000001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] hun_i,
  input  logic [6:0] ten_i,
  input  logic [6:0] uni_i,
  input  logic       load_i,
  output logic [6:0] seg_o,
  output logic [2:0] an_o,
  output logic       commit_o
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] GuardCnt = CntW'(GUARD);

  typedef enum logic [1:0] {
    StUnits = 2'd0,
    StTens  = 2'd1,
    StHuns  = 2'd2
  } idx_e;

  // Shadow/pending layout: {hundreds[20:14], tens[13:7], units[6:0]}.
  logic [20:0]     pending_q, pending_d;
  logic            pend_valid_q, pend_valid_d;
  logic [20:0]     shadow_q, shadow_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  idx_e            idx_q, idx_d;
  logic [6:0]      seg_d;
  logic [2:0]      an_d;
  logic            commit_d;

  logic            slot_end;
  logic            boundary;
  logic            blank_hun;
  logic            blank_ten;

  assign slot_end = (cnt_q == CntMax);
  assign boundary = slot_end && (idx_q == StHuns);

`ifdef SEG_SCAN_BLANK_EN
  assign blank_hun = (shadow_q[20:14] == ZERO_PAT);
  assign blank_ten = blank_hun && (shadow_q[13:7] == ZERO_PAT);
`else
  assign blank_hun = 1'b0;
  assign blank_ten = 1'b0;
`endif

  // State register: scan position plus data buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= StUnits;
      pending_q    <= '1;
      pend_valid_q <= 1'b0;
      shadow_q     <= '1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      shadow_q     <= shadow_d;
    end
  end

  // Next-state: the scan never stalls; buffers only move at load or boundary.
  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    shadow_d     = shadow_q;
    commit_d     = 1'b0;

    if (slot_end) begin
      cnt_d = '0;
      case (idx_q)
        StUnits: idx_d = StTens;
        StTens:  idx_d = StHuns;
        default: idx_d = StUnits;
      endcase
    end

    if (boundary) begin
      // A load on the boundary itself is newer than anything pending, so it goes straight in.
      if (load_i) begin
        shadow_d     = {hun_i, ten_i, uni_i};
        pend_valid_d = 1'b0;
        commit_d     = 1'b1;
      end else if (pend_valid_q) begin
        shadow_d     = pending_q;
        pend_valid_d = 1'b0;
        commit_d     = 1'b1;
      end
    end else if (load_i) begin
      pending_d    = {hun_i, ten_i, uni_i};
      pend_valid_d = 1'b1;
    end
  end

  // Output decode from the current scan position; registered below.
  always_comb begin
    logic [6:0] field;
    logic       blank;
    seg_d = 7'h7F;
    an_d  = 3'b111;
    field = shadow_q[6:0];
    blank = 1'b0;
    case (idx_q)
      StTens: begin
        field = shadow_q[13:7];
        blank = blank_ten;
      end
      StHuns: begin
        field = shadow_q[20:14];
        blank = blank_hun;
      end
      default: begin
        field = shadow_q[6:0];
        blank = 1'b0;
      end
    endcase
    if ((cnt_q >= GuardCnt) && !blank) begin
      an_d  = ~(3'b001 << idx_q);
      seg_d = field;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o    <= 7'h7F;
      an_o     <= 3'b111;
      commit_o <= 1'b0;
    end else begin
      seg_o    <= seg_d;
      an_o     <= an_d;
      commit_o <= commit_d;
    end
  end

endmodule
